trng_conditioner: RTL and testbench

- Sits directly upstream of the rng word assembler.
- Takes raw sampled entropy bits from the ring-oscillator sampler and removes bias with a von Neumann corrector.
- Runs a continuous repetition-count health test on the raw stream.
- Buffers conditioned bits in a small FIFO and presents them on a trng_bit / trng_next style interface, so the assembler only sees bits that are debiased and health-checked.

---
 rtl/trng_conditioner.sv | 160 ++++++++++++++++
 tb/tb_trng_conditioner.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/trng_conditioner.sv
// Von Neumann debiaser with repetition-count health test feeding a small conditioned-bit FIFO.
// Optional adaptive proportion test is enabled by defining TRNG_CONDITIONER_APT_EN.
module trng_conditioner #(
    parameter int DEPTH      = 8,
    parameter int RCT_CUTOFF = 16,
    parameter int APT_WINDOW = 64,
    parameter int APT_CUTOFF = 48
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic                       raw_bit,
    input  logic                       raw_valid,
    input  logic                       trng_next,
    output logic                       trng_bit,
    output logic                       bit_valid,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level,
    output logic                       health_fail,
    output logic                       overflow,
    input  logic                       clear_fail
);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = $clog2(RCT_CUTOFF + 1);

    typedef enum logic [1:0] {IDLE_PAIR, HAVE_FIRST, FAILED} state_t;

    state_t          state;
    logic            first_bit;
    logic            mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [LW-1:0]   level;
    logic [RW-1:0]   rep_cnt;
    logic [RW-1:0]   rep_next;
    logic            has_hist;
    logic            last_raw;
    logic            raw_ev;
    logic            rct_trig;
    logic            apt_trig;
    logic            health_trig;
    logic            emit;
    logic            push;
    logic            pop;
    logic            drop;

    // clear_fail wins over a coincident sample, so the sample never reaches either test
    assign raw_ev   = en && raw_valid && !clear_fail;
    assign rep_next = (has_hist && (raw_bit == last_raw))
                      ? ((rep_cnt == RW'(RCT_CUTOFF)) ? rep_cnt : rep_cnt + 1'b1)
                      : RW'(1);
    assign rct_trig    = raw_ev && (rep_next == RW'(RCT_CUTOFF));
    assign health_trig = rct_trig || apt_trig;

    assign pop  = en && trng_next && (level != '0) && !health_fail && !health_trig;
    assign emit = raw_ev && (state == HAVE_FIRST) && (raw_bit != first_bit) && !health_trig;
    assign push = emit && ((level != LW'(DEPTH)) || pop);
    assign drop = emit && !push;

    assign trng_bit   = (level != '0) ? mem[rd_ptr] : 1'b0;
    assign bit_valid  = (level != '0) && !health_fail;
    assign fifo_level = level;

`ifdef TRNG_CONDITIONER_APT_EN
    localparam int AW = $clog2(APT_WINDOW + 1);

    logic [AW-1:0] apt_idx;
    logic [AW-1:0] apt_cnt;
    logic [AW-1:0] apt_cnt_next;
    logic          apt_ref;

    // the first sample of a window is its own reference and counts as a match
    assign apt_cnt_next = (apt_idx == '0) ? AW'(1)
                          : apt_cnt + AW'(raw_bit == apt_ref);
    assign apt_trig     = raw_ev && (apt_cnt_next == AW'(APT_CUTOFF));

    always_ff @(posedge clk) begin
        if (reset) begin
            apt_idx <= '0;
            apt_cnt <= '0;
            apt_ref <= 1'b0;
        end else if (en) begin
            if (clear_fail) begin
                apt_idx <= '0;
                apt_cnt <= '0;
            end else if (raw_valid) begin
                if (apt_idx == '0)
                    apt_ref <= raw_bit;
                apt_cnt <= apt_cnt_next;
                apt_idx <= (apt_idx == AW'(APT_WINDOW - 1)) ? '0 : apt_idx + 1'b1;
            end
        end
    end
`else
    // window parameters stay in the port map for drop-in compatibility; this folds to 0
    assign apt_trig = (APT_CUTOFF >= APT_WINDOW) && 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= first_bit;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE_PAIR;
            first_bit   <= 1'b0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            rep_cnt     <= '0;
            has_hist    <= 1'b0;
            last_raw    <= 1'b0;
            health_fail <= 1'b0;
            overflow    <= 1'b0;
        end else if (en) begin
            if (clear_fail) begin
                health_fail <= 1'b0;
                overflow    <= 1'b0;
                rep_cnt     <= '0;
                has_hist    <= 1'b0;
                if (state == FAILED)
                    state <= IDLE_PAIR;
            end else if (raw_valid) begin
                rep_cnt  <= rep_next;
                has_hist <= 1'b1;
                last_raw <= raw_bit;
            end

            if (health_trig) begin
                health_fail <= 1'b1;
                state       <= FAILED;
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                level       <= '0;
            end else begin
                if (raw_ev) begin
                    case (state)
                        IDLE_PAIR: begin
                            first_bit <= raw_bit;
                            state     <= HAVE_FIRST;
                        end
                        HAVE_FIRST: state <= IDLE_PAIR;
                        default:    state <= state;
                    endcase
                end
                if (push)
                    wr_ptr <= wr_ptr + 1'b1;
                if (pop)
                    rd_ptr <= rd_ptr + 1'b1;
                if (push && !pop)
                    level <= level + 1'b1;
                else if (pop && !push)
                    level <= level - 1'b1;
                if (drop)
                    overflow <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_trng_conditioner.sv
// Bench for trng_conditioner: fixed vector table, corner sequences and randomized traffic against a queue model.
module tb_trng_conditioner;
    localparam int DEPTH = 8;
    localparam int RCT   = 16;
    localparam int APT_W = 64;
    localparam int APT_C = 48;

    logic       clk = 1'b0;
    logic       reset, en, raw_bit, raw_valid, trng_next, clear_fail;
    logic       trng_bit, bit_valid, health_fail, overflow;
    logic [3:0] fifo_level;

    int total = 0;
    int bad   = 0;

    trng_conditioner #(.DEPTH(DEPTH), .RCT_CUTOFF(RCT), .APT_WINDOW(APT_W), .APT_CUTOFF(APT_C)) dut (
        .clk(clk), .reset(reset), .en(en), .raw_bit(raw_bit), .raw_valid(raw_valid),
        .trng_next(trng_next), .trng_bit(trng_bit), .bit_valid(bit_valid),
        .fifo_level(fifo_level), .health_fail(health_fail), .overflow(overflow),
        .clear_fail(clear_fail)
    );

    always #5 clk = ~clk;

    // reference model: conditioned bits as a queue, health state as plain counters
    bit mq[$];
    bit m_fail, m_ovf, m_hf, m_first, m_hist, m_last, m_wref;
    int m_rep, m_wn, m_wm;

    task automatic model_upd(input bit r, input bit e, input bit rv, input bit rb,
                             input bit nx, input bit cf);
        bit trig;
        bit pop_ok;
        if (r) begin
            mq.delete();
            m_fail = 0; m_ovf = 0; m_hf = 0; m_first = 0; m_hist = 0; m_last = 0;
            m_rep = 0; m_wn = 0; m_wm = 0; m_wref = 0;
            return;
        end
        if (!e) return;
        pop_ok = nx && (mq.size() > 0) && !m_fail;
        if (cf) begin
            m_fail = 0; m_ovf = 0; m_rep = 0; m_hist = 0; m_wn = 0; m_wm = 0;
            if (pop_ok) void'(mq.pop_front());
            return;
        end
        trig = 0;
        if (rv) begin
            if (m_hist && rb == m_last) m_rep = (m_rep + 1 > RCT) ? RCT : m_rep + 1;
            else m_rep = 1;
            m_hist = 1;
            m_last = rb;
            if (m_rep == RCT) trig = 1;
            if (m_wn == 0) begin
                m_wref = rb;
                m_wm = 1;
            end else if (rb == m_wref) begin
                m_wm++;
            end
            m_wn++;
            if (m_wn == APT_W) m_wn = 0;
`ifdef TRNG_CONDITIONER_APT_EN
            if (m_wm == APT_C && (m_wn == 0 || rb == m_wref || m_wn == 1)) trig = 1;
`endif
        end
        if (trig) begin
            m_fail = 1;
            m_hf = 0;
            mq.delete();
        end else if (!m_fail) begin
            if (pop_ok) void'(mq.pop_front());
            if (rv) begin
                if (!m_hf) begin
                    m_first = rb;
                    m_hf = 1;
                end else begin
                    m_hf = 0;
                    if (rb != m_first) begin
                        if (mq.size() < DEPTH) mq.push_back(m_first);
                        else m_ovf = 1;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit e, input bit rv, input bit rb,
                        input bit nx, input bit cf);
        reset = r; en = e; raw_valid = rv; raw_bit = rb; trng_next = nx; clear_fail = cf;
        @(posedge clk);
        model_upd(r, e, rv, rb, nx, cf);
        #1;
        chk("model_level", int'(fifo_level), mq.size());
        chk("model_bit", int'(trng_bit), (mq.size() > 0) ? int'(mq[0]) : 0);
        chk("model_valid", int'(bit_valid), int'(mq.size() > 0 && !m_fail));
        chk("model_fail", int'(health_fail), int'(m_fail));
        chk("model_ovf", int'(overflow), int'(m_ovf));
    endtask

    typedef struct {
        bit r, e, rv, rb, nx, cf;
        int lvl;
        bit tbit, vld, fl, ov;
    } vec_t;
    vec_t vt[$];

    task automatic add(input bit r, input bit e, input bit rv, input bit rb, input bit nx,
                       input bit cf, input int lvl, input bit tbit, input bit vld,
                       input bit fl, input bit ov);
        vec_t v;
        v.r = r; v.e = e; v.rv = rv; v.rb = rb; v.nx = nx; v.cf = cf;
        v.lvl = lvl; v.tbit = tbit; v.vld = vld; v.fl = fl; v.ov = ov;
        vt.push_back(v);
    endtask

    initial begin
        bit rb_r;
        int stick;
        reset = 1; en = 0; raw_valid = 0; raw_bit = 0; trng_next = 0; clear_fail = 0;

        //  r  e rv rb nx cf | lvl bit vld fail ovf
        add(1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 0,   0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 0,   1, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0,   1, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0,   2, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0,   2, 0, 1, 0, 0);
        add(0, 1, 1, 0, 0, 0,   2, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0,   2, 0, 1, 0, 0);
        add(0, 1, 1, 1, 0, 0,   2, 0, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0,   1, 1, 1, 0, 0);
        add(0, 0, 0, 0, 1, 0,   1, 1, 1, 0, 0);
        add(0, 1, 0, 0, 0, 1,   1, 1, 1, 0, 0);
        foreach (vt[i]) begin
            step(vt[i].r, vt[i].e, vt[i].rv, vt[i].rb, vt[i].nx, vt[i].cf);
            chk("tbl_level", int'(fifo_level), vt[i].lvl);
            chk("tbl_bit", int'(trng_bit), int'(vt[i].tbit));
            chk("tbl_valid", int'(bit_valid), int'(vt[i].vld));
            chk("tbl_fail", int'(health_fail), int'(vt[i].fl));
            chk("tbl_ovf", int'(overflow), int'(vt[i].ov));
        end

        // repetition count: 15 ones are tolerated, 16 trip the test and flush the FIFO
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++) step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("rct15_fail", int'(health_fail), 0);
        chk("rct15_level", int'(fifo_level), 1);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 1, 0, 0);
            if (i == 14) chk("rct_pre_fail", int'(health_fail), 0);
        end
        chk("rct16_fail", int'(health_fail), 1);
        chk("rct16_level", int'(fifo_level), 0);
        chk("rct16_valid", int'(bit_valid), 0);
        step(0, 1, 1, 0, 1, 0);
        step(0, 1, 1, 1, 0, 0);
        chk("failed_level", int'(fifo_level), 0);
        step(0, 1, 1, 1, 0, 1);
        chk("clear_fail", int'(health_fail), 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 0, 0);
        chk("post_clear_level", int'(fifo_level), 1);

        // overflow: 8 zeros fill, a ninth bit (1) is dropped
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 1, 0, 0, 0);
            step(0, 1, 1, 1, 0, 0);
        end
        step(0, 1, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        chk("full_level", int'(fifo_level), 8);
        chk("full_ovf", int'(overflow), 1);
        step(0, 1, 1, 0, 0, 0);
        step(0, 1, 1, 1, 1, 0);
        chk("pushpop_level", int'(fifo_level), 8);
        chk("pushpop_ovf", int'(overflow), 1);
        for (int i = 0; i < 8; i++) begin
            chk("drain_bit", int'(trng_bit), 0);
            step(0, 1, 0, 0, 1, 0);
        end
        chk("drained_level", int'(fifo_level), 0);

        // enable gating mid-pair
        step(1, 1, 0, 0, 0, 0);
        step(0, 1, 1, 0, 0, 0);
        step(0, 0, 1, 1, 1, 1);
        chk("en_off_level", int'(fifo_level), 0);
        step(0, 1, 1, 1, 0, 0);
        chk("en_resume_level", int'(fifo_level), 1);
        chk("en_resume_bit", int'(trng_bit), 0);

        // adaptive proportion pattern 1,1,1,0: 48th match lands on sample index 62
        step(1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 64; i++) begin
            step(0, 1, 1, (i % 4) != 3, 1, 0);
            if (i == 61) chk("apt_pre", int'(health_fail), 0);
`ifdef TRNG_CONDITIONER_APT_EN
            if (i == 62) chk("apt_trip", int'(health_fail), 1);
`else
            if (i == 62) chk("apt_absent", int'(health_fail), 0);
`endif
        end

        // randomized traffic with sticky phases to exercise long runs
        step(1, 1, 0, 0, 0, 0);
        rb_r = 0;
        stick = 30;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) stick = $urandom_range(20, 97);
            if ($urandom_range(0, 99) >= stick) rb_r = $urandom_range(0, 1);
            step($urandom_range(0, 999) == 0, ($urandom_range(0, 15) != 0),
                 ($urandom_range(0, 3) != 0), rb_r, ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 99) < 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
